// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified memory port between instruction fetch and data access.
// The winning request is registered and held on the bus until the memory acknowledges or the wait limit expires.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [3:0] streak;
  logic [7:0] wait_cnt;
  logic       grant_d;
  logic       pick_d;
  logic       pick_if;

  // Data normally wins a tie; once it has won MAX_DATA_STREAK times in a row over a waiting fetch, fetch goes next.
  always_comb begin
    pick_d  = d_req && (!if_req || (streak != STREAK_MAX));
    pick_if = if_req && !pick_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      wait_cnt  <= '0;
      grant_d   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      busy      <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            grant_d   <= 1'b1;
            mem_valid <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wmask <= d_wmask;
            busy      <= 1'b1;
            state     <= ACCESS;
            if (!if_req)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 4'd1;
          end else if (pick_if) begin
            grant_d   <= 1'b0;
            mem_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wmask <= '0;
            busy      <= 1'b1;
            state     <= ACCESS;
            streak    <= '0;
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= DONE;
            if (grant_d) begin
              d_done <= 1'b1;
              if (!mem_we)
                d_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            // Abort on the cycle the wait count would reach the limit; loads and fetches return zero.
            if (wait_cnt == WAIT_LAST) begin
              mem_valid <= 1'b0;
              state     <= DONE;
              err       <= 1'b1;
              if (grant_d) begin
                d_done <= 1'b1;
                if (!mem_we)
                  d_rdata <= '0;
              end else begin
                if_done  <= 1'b1;
                if_rdata <= '0;
              end
            end
          end
        end

        DONE: begin
          wait_cnt <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          mem_valid <= 1'b0;
          wait_cnt  <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
